// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: FSM state encoding,
// ALU op codes and default widths.
package alu_seq_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ADDR_W = 3;
    localparam int unsigned DEF_OP_W   = 3;

    localparam logic [DEF_OP_W-1:0] ALU_ADD = 3'd0;
    localparam logic [DEF_OP_W-1:0] ALU_AND = 3'd2;
    localparam logic [DEF_OP_W-1:0] ALU_OR  = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WRITE,
        ST_RESP
    } seq_state_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response channels of the ALU command sequencer.
// master = command source / result consumer, slave = sequencer.
interface alu_cmd_sequencer_if
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned OP_W   = DEF_OP_W
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_load;
    logic [OP_W-1:0]   cmd_op;
    logic [ADDR_W-1:0] cmd_rd;
    logic [ADDR_W-1:0] cmd_rs1;
    logic [ADDR_W-1:0] cmd_rs2;
    logic [DATA_W-1:0] cmd_imm;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] rsp_rd;

    modport master (
        output cmd_valid, cmd_load, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        output rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_rd
    );

    modport slave (
        input  cmd_valid, cmd_load, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        input  rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_rd
    );

endinterface

// File: rtl/alu_cmd_sequencer.sv
// ALU command sequencer: accepts one load-immediate or register-register ALU
// command, drives the regfile read/write ports and the ALU, then returns the
// written value on the response channel.
// Optional macro ALUSEQ_R0_ZERO_EN: register 0 reads as zero and ignores writes.
// The interface instance must use the same DATA_W/ADDR_W/OP_W as this module.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned OP_W   = DEF_OP_W
) (
    input  logic              clk,
    input  logic              rst,
    alu_cmd_sequencer_if.slave bus,
    output logic              w_en,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic [ADDR_W-1:0] read_addr1,
    output logic [ADDR_W-1:0] read_addr2,
    input  logic [DATA_W-1:0] read_data1,
    input  logic [DATA_W-1:0] read_data2,
    output logic [DATA_W-1:0] in_b,
    output logic [DATA_W-1:0] in_c,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_out
);

`ifdef ALUSEQ_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    seq_state_t        state;
    logic              cmd_ready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [ADDR_W-1:0] rsp_rd_q;
    logic [ADDR_W-1:0] rd_q;
    logic [OP_W-1:0]   op_q;
    logic              w_en_q;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return R0_ZERO && (addr == '0);
    endfunction

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_rd    = rsp_rd_q;

    // Gated by rst so a reset landing in WRITE never reaches the regfile.
    assign w_en = w_en_q & ~rst;

    // Sequencer FSM; write_data doubles as the result register between EXEC and RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_rd_q    <= '0;
            rd_q        <= '0;
            op_q        <= '0;
            w_en_q      <= 1'b0;
            write_addr  <= '0;
            write_data  <= '0;
            read_addr1  <= '0;
            read_addr2  <= '0;
            in_b        <= '0;
            in_c        <= '0;
            alu_op      <= '0;
        end else begin
            w_en_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        rd_q        <= bus.cmd_rd;
                        op_q        <= bus.cmd_op;
                        read_addr1  <= bus.cmd_rs1;
                        read_addr2  <= bus.cmd_rs2;
                        if (bus.cmd_load) begin
                            w_en_q     <= !is_zero_reg(bus.cmd_rd);
                            write_addr <= bus.cmd_rd;
                            write_data <= bus.cmd_imm;
                            state      <= ST_WRITE;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    in_b   <= is_zero_reg(read_addr1) ? '0 : read_data1;
                    in_c   <= is_zero_reg(read_addr2) ? '0 : read_data2;
                    alu_op <= op_q;
                    state  <= ST_EXEC;
                end
                ST_EXEC: begin
                    w_en_q     <= !is_zero_reg(rd_q);
                    write_addr <= rd_q;
                    write_data <= alu_out;
                    state      <= ST_WRITE;
                end
                ST_WRITE: begin
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= is_zero_reg(rd_q) ? '0 : write_data;
                    rsp_rd_q    <= rd_q;
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    cmd_ready_q <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with behavioural regfile and ALU.
// Honours ALUSEQ_R0_ZERO_EN for the register-0 vectors.
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 3;
    localparam int unsigned OW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          w_en;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;
    logic [AW-1:0] read_addr1, read_addr2;
    logic [DW-1:0] read_data1, read_data2;
    logic [DW-1:0] in_b, in_c;
    logic [OW-1:0] alu_op;
    logic [DW-1:0] alu_out;

    int checks = 0;
    int errors = 0;
    int wen_count = 0;

    logic [DW-1:0] regs [8];

    alu_cmd_sequencer_if #(.DATA_W(DW), .ADDR_W(AW), .OP_W(OW)) bus ();

    alu_cmd_sequencer #(.DATA_W(DW), .ADDR_W(AW), .OP_W(OW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .w_en       (w_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_addr1 (read_addr1),
        .read_addr2 (read_addr2),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .in_b       (in_b),
        .in_c       (in_c),
        .alu_op     (alu_op),
        .alu_out    (alu_out)
    );

    always #5 clk = ~clk;

    // Regfile model: synchronous write, combinational read; also counts write pulses.
    always @(posedge clk) begin
        if (w_en) begin
            regs[write_addr] <= write_data;
            wen_count <= wen_count + 1;
        end
    end

    assign read_data1 = regs[read_addr1];
    assign read_data2 = regs[read_addr2];

    // ALU model.
    always_comb begin
        alu_out = '0;
        case (alu_op)
            ALU_ADD: alu_out = in_b + in_c;
            ALU_AND: alu_out = in_b & in_c;
            ALU_OR:  alu_out = in_b | in_c;
            default: alu_out = in_b ^ in_c;
        endcase
    end

    typedef struct {
        logic          load;
        logic [OW-1:0] op;
        logic [AW-1:0] rd;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [DW-1:0] imm;
        logic [DW-1:0] exp;
        logic          exp_wen;
        int unsigned   hold;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ld, input logic [OW-1:0] op,
                                input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                                input logic [AW-1:0] rs2, input logic [DW-1:0] imm,
                                input logic [DW-1:0] exp, input logic exp_wen,
                                input int unsigned hold);
        vec_t v;
        v.load = ld; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.imm = imm; v.exp = exp; v.exp_wen = exp_wen; v.hold = hold;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin
            tick();
            n++;
        end
        chk("cmd_ready_before_issue", bus.cmd_ready, 1);
    endtask

    task automatic drive_cmd(input vec_t v);
        bus.cmd_load  = v.load;
        bus.cmd_op    = v.op;
        bus.cmd_rd    = v.rd;
        bus.cmd_rs1   = v.rs1;
        bus.cmd_rs2   = v.rs2;
        bus.cmd_imm   = v.imm;
        bus.cmd_valid = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int            wcyc, rcyc, wcnt;
        logic          busy_rdy;
        logic [DW-1:0] wd;
        logic [AW-1:0] wa;
        wait_ready();
        bus.rsp_ready = 1'b0;
        drive_cmd(v);
        tick();
        bus.cmd_valid = 1'b0;
        wcyc = 0; rcyc = 0; wcnt = 0; busy_rdy = 1'b0; wd = '0; wa = '0;
        for (int c = 1; c <= 8 && rcyc == 0; c++) begin
            if (bus.cmd_ready) busy_rdy = 1'b1;
            if (w_en) begin
                wcnt++;
                wcyc = c;
                wd = write_data;
                wa = write_addr;
            end
            if (bus.rsp_valid) rcyc = c;
            else tick();
        end
        chk("wen_pulses", wcnt, v.exp_wen ? 1 : 0);
        if (v.exp_wen) begin
            chk("wen_cycle", wcyc, v.load ? 1 : 3);
            chk("write_addr", wa, v.rd);
            chk("write_data", wd, v.exp);
        end
        chk("rsp_cycle", rcyc, v.load ? 2 : 4);
        chk("cmd_ready_while_busy", busy_rdy, 0);
        chk("rsp_data", bus.rsp_data, v.exp);
        chk("rsp_rd", bus.rsp_rd, v.rd);
        for (int unsigned h = 0; h < v.hold; h++) begin
            tick();
            chk("hold_rsp_valid", bus.rsp_valid, 1);
            chk("hold_rsp_data", bus.rsp_data, v.exp);
            chk("hold_cmd_ready", bus.cmd_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_after_hs", bus.rsp_valid, 0);
        chk("cmd_ready_after_hs", bus.cmd_ready, 1);
        if (v.exp_wen) chk("regfile_rd", regs[v.rd], v.exp);
    endtask

    initial begin
        int base;
        vec_t v;

        bus.cmd_valid = 1'b0; bus.cmd_load = 1'b0; bus.cmd_op = '0;
        bus.cmd_rd = '0; bus.cmd_rs1 = '0; bus.cmd_rs2 = '0; bus.cmd_imm = '0;
        bus.rsp_ready = 1'b0;

        //       ld  op       rd rs1 rs2 imm    exp    wen hold
        vecs.push_back(mk(1, ALU_ADD, 1, 0, 0, 8'h02, 8'h02, 1, 0));
        vecs.push_back(mk(1, ALU_ADD, 2, 0, 0, 8'h03, 8'h03, 1, 0));
        vecs.push_back(mk(0, ALU_ADD, 3, 1, 2, 8'h00, 8'h05, 1, 0));
        vecs.push_back(mk(0, ALU_AND, 3, 1, 2, 8'h00, 8'h02, 1, 0));
        vecs.push_back(mk(0, ALU_OR,  3, 1, 2, 8'h00, 8'h03, 1, 0));
        vecs.push_back(mk(1, ALU_ADD, 4, 0, 0, 8'hFF, 8'hFF, 1, 0));
        vecs.push_back(mk(1, ALU_ADD, 5, 0, 0, 8'h02, 8'h02, 1, 0));
        vecs.push_back(mk(0, ALU_ADD, 6, 4, 5, 8'h00, 8'h01, 1, 0));
        vecs.push_back(mk(0, ALU_ADD, 3, 1, 2, 8'h00, 8'h05, 1, 3));
        vecs.push_back(mk(0, ALU_ADD, 1, 1, 2, 8'h00, 8'h05, 1, 0));
`ifdef ALUSEQ_R0_ZERO_EN
        vecs.push_back(mk(1, ALU_ADD, 0, 0, 0, 8'h07, 8'h00, 0, 0));
        vecs.push_back(mk(0, ALU_ADD, 4, 0, 2, 8'h00, 8'h03, 1, 0));
`else
        vecs.push_back(mk(1, ALU_ADD, 0, 0, 0, 8'h07, 8'h07, 1, 0));
        vecs.push_back(mk(0, ALU_ADD, 4, 0, 2, 8'h00, 8'h0A, 1, 0));
`endif

        // Reset state.
        repeat (2) tick();
        chk("reset_outputs_zero",
            {w_en, bus.rsp_valid, bus.rsp_data, bus.rsp_rd, write_addr, write_data,
             read_addr1, read_addr2, in_b, in_c, alu_op}, 64'd0);
        rst = 1'b0;
        tick();
        chk("cmd_ready_after_reset", bus.cmd_ready, 1);
        chk("rsp_valid_after_reset", bus.rsp_valid, 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset during EXEC of ADD r3=r1+r2 (r1=5, r2=3): aborted, r3 stays 5.
        wait_ready();
        base = wen_count;
        v = mk(0, ALU_ADD, 3, 1, 2, 8'h00, 8'h08, 1, 0);
        drive_cmd(v);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        chk("exec_in_b", in_b, 8'h05);
        chk("exec_in_c", in_c, 8'h03);
        chk("exec_alu_op", alu_op, ALU_ADD);
        rst = 1'b1;
        tick();
        chk("rst_exec_outputs_zero",
            {w_en, bus.rsp_valid, bus.rsp_data, bus.rsp_rd, write_addr, write_data,
             read_addr1, read_addr2, in_b, in_c, alu_op}, 64'd0);
        rst = 1'b0;
        tick();
        chk("rst_exec_cmd_ready", bus.cmd_ready, 1);
        chk("rst_exec_no_wen", wen_count - base, 0);
        chk("rst_exec_r3_kept", regs[3], 8'h05);

        // Reset landing in WRITE of a load: w_en must drop in the reset cycle.
        wait_ready();
        base = wen_count;
        v = mk(1, ALU_ADD, 3, 0, 0, 8'h99, 8'h99, 1, 0);
        drive_cmd(v);
        tick();
        bus.cmd_valid = 1'b0;
        chk("write_state_wen", w_en, 1);
        rst = 1'b1;
        #1;
        chk("rst_write_wen_gated", w_en, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("rst_write_no_wen", wen_count - base, 0);
        chk("rst_write_r3_kept", regs[3], 8'h05);
        chk("rst_write_cmd_ready", bus.cmd_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
